divider_seq_ctrl: RTL and testbench

//  Upstream sequencer for the gated-clock 4-bit divider stage; the divider has no handshake of its own.
//  - Accepts a dividend/divisor pair over a valid/ready handshake.
//  - Holds the operands stable, clears the divider, then gates its clock for a fixed run window.
//  - Samples the latched quotient and presents it downstream with valid/ready and a divide-by-zero flag.

---
 rtl/divider_seq_pkg.sv | 23 ++
 rtl/divider_seq_ctrl_run_timer.sv | 29 ++
 rtl/divider_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_divider_seq_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/divider_seq_pkg.sv
// Shared types and constants for the gated-clock divider sequencer.
// The FSM encoding and the divide-by-zero result value live here.
package divider_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int C_RUN_CYCLES_DEFAULT = 10;

  // All-ones pattern of the requested width, used as the quotient on divide-by-zero.
  function automatic logic [31:0] dbz_value(input int width);
    logic [31:0] v;
    if (width >= 32) v = '1;
    else             v = (32'h1 << width) - 32'h1;
    return v;
  endfunction

endpackage

// File: rtl/divider_seq_ctrl_run_timer.sv
// Run-window timer: cleared by load, counts while enabled, saturates at
// all-ones and pulses o_tc while enabled on the terminal count.
module run_timer #(
  parameter int C_CNT_BITS = 4,
  parameter int C_TERMINAL = 9
) (
  input  logic CK,
  input  logic R,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [C_CNT_BITS-1:0] C_MAX = '1;
  localparam logic [C_CNT_BITS-1:0] C_TC  = C_CNT_BITS'(C_TERMINAL);

  logic [C_CNT_BITS-1:0] r_cnt;

  always_ff @(posedge CK) begin
    if (R || i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = i_en && (r_cnt == C_TC);

endmodule

// File: rtl/divider_seq_ctrl.sv
// Upstream sequencer for the gated-clock divider: accepts an operand pair,
// clears and runs the divider for a fixed window, then presents the quotient.
module divider_seq_ctrl
  import divider_seq_pkg::*;
#(
  parameter int C_NUM_BITS   = 4,
  parameter int C_RUN_CYCLES = C_RUN_CYCLES_DEFAULT,
  parameter int C_CNT_BITS   = 4
) (
  input  logic                  CK,
  input  logic                  R,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [C_NUM_BITS-1:0] IN_A,
  input  logic [C_NUM_BITS-1:0] IN_B,
  output logic                  DIV_E,
  output logic                  DIV_RN,
  output logic [C_NUM_BITS-1:0] DIV_A,
  output logic [C_NUM_BITS-1:0] DIV_B,
  input  logic [C_NUM_BITS-1:0] DIV_Q,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [C_NUM_BITS-1:0] OUT_Q,
  output logic                  OUT_DBZ
);

  localparam logic [C_NUM_BITS-1:0] C_DBZ_Q = C_NUM_BITS'(dbz_value(C_NUM_BITS));

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_b_zero;
  logic                  w_tc;
  logic                  w_div_e_nxt;
  logic                  w_div_rn_nxt;
  logic                  r_div_e;
  logic                  r_div_rn;
  logic [C_NUM_BITS-1:0] r_div_a;
  logic [C_NUM_BITS-1:0] r_div_b;
  logic [C_NUM_BITS-1:0] r_out_q;
  logic                  r_out_dbz;

  assign w_accept = IN_VALID && (r_state == IDLE);
  assign w_b_zero = (IN_B == '0);

  run_timer #(
    .C_CNT_BITS (C_CNT_BITS),
    .C_TERMINAL (C_RUN_CYCLES - 1)
  ) u_run_timer (
    .CK     (CK),
    .R      (R),
    .i_load (r_state == CLEAR),
    .i_en   (r_state == RUN),
    .o_tc   (w_tc)
  );

  always_ff @(posedge CK) begin
    if (R) r_state <= IDLE;
    else   r_state <= w_next;
  end

  // Gate enable and divider reset are registered from the next state so the
  // clock gate and the divider's reset pin never see decode glitches.
  always_comb begin
    w_next       = IDLE;
    w_div_e_nxt  = 1'b0;
    w_div_rn_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_b_zero ? DONE : CLEAR;
        else          w_next = IDLE;
      end
      CLEAR:   w_next = RUN;
      RUN:     w_next = w_tc ? CAPTURE : RUN;
      CAPTURE: w_next = DONE;
      DONE:    w_next = OUT_READY ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
    w_div_e_nxt  = (w_next == CLEAR) || (w_next == RUN);
    w_div_rn_nxt = (w_next == RUN);
  end

  always_ff @(posedge CK) begin
    if (R) begin
      r_div_e  <= 1'b0;
      r_div_rn <= 1'b0;
    end else begin
      r_div_e  <= w_div_e_nxt;
      r_div_rn <= w_div_rn_nxt;
    end
  end

  // Operands stay frozen from acceptance until the next accept in IDLE.
  always_ff @(posedge CK) begin
    if (R) begin
      r_div_a <= '0;
      r_div_b <= '0;
    end else if (w_accept) begin
      r_div_a <= IN_A;
      r_div_b <= IN_B;
    end
  end

  always_ff @(posedge CK) begin
    if (R) begin
      r_out_q   <= '0;
      r_out_dbz <= 1'b0;
    end else if (w_accept && w_b_zero) begin
      r_out_q   <= C_DBZ_Q;
      r_out_dbz <= 1'b1;
    end else if (r_state == CAPTURE) begin
      r_out_q   <= DIV_Q;
      r_out_dbz <= 1'b0;
    end
  end

  assign IN_READY  = (r_state == IDLE);
  assign OUT_VALID = (r_state == DONE);
  assign DIV_E     = r_div_e;
  assign DIV_RN    = r_div_rn;
  assign DIV_A     = r_div_a;
  assign DIV_B     = r_div_b;
  assign OUT_Q     = r_out_q;
  assign OUT_DBZ   = r_out_dbz;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Bench for divider_seq_ctrl with a behavioural gated divider attached to
// the DIV_* pins and directed plus randomized operand pairs.
module tb_divider_seq_ctrl;

  localparam int NB = 4;
  localparam int RC = 10;

  logic          CK = 1'b0;
  logic          R;
  logic          IN_VALID;
  logic          IN_READY;
  logic [NB-1:0] IN_A;
  logic [NB-1:0] IN_B;
  logic          DIV_E;
  logic          DIV_RN;
  logic [NB-1:0] DIV_A;
  logic [NB-1:0] DIV_B;
  logic [NB-1:0] DIV_Q;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [NB-1:0] OUT_Q;
  logic          OUT_DBZ;

  int total = 0;
  int bad   = 0;

  divider_seq_ctrl #(.C_NUM_BITS(NB), .C_RUN_CYCLES(RC), .C_CNT_BITS(4)) dut (
    .CK(CK), .R(R), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
    .DIV_E(DIV_E), .DIV_RN(DIV_RN), .DIV_A(DIV_A), .DIV_B(DIV_B), .DIV_Q(DIV_Q),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Q(OUT_Q), .OUT_DBZ(OUT_DBZ)
  );

  always #5 CK = ~CK;

  // Divider model: counts enabled clocks since its last reset; the quotient
  // latch shows the true result only at exactly RC counts, garbage otherwise.
  int dcnt = 0;
  always @(posedge CK) begin
    if (DIV_E) dcnt <= DIV_RN ? dcnt + 1 : 0;
  end

  always_comb begin
    logic [NB-1:0] q;
    q = (DIV_B == '0) ? '1 : DIV_A / DIV_B;
    DIV_Q = (dcnt == RC) ? q : (q ^ 4'h5);
  end

  // Running totals of enable activity; ops take snapshots and compare deltas.
  int e_tot = 0, clr_tot = 0, run_tot = 0, rn_noe_tot = 0;
  always @(posedge CK) begin
    if (DIV_E) e_tot <= e_tot + 1;
    if (DIV_E && !DIV_RN) clr_tot <= clr_tot + 1;
    if (DIV_E && DIV_RN) run_tot <= run_tot + 1;
    if (!DIV_E && DIV_RN) rn_noe_tot <= rn_noe_tot + 1;
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: accept, wait for result, optional backpressure,
  // result handshake with a competing IN_VALID, then enable-activity audit.
  task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input int hold);
    logic [NB-1:0] eq;
    logic          edbz;
    int            lat, e0, c0, r0, n0;
    logic          opnd_ok, hold_ok;
    edbz = (b == '0);
    eq   = edbz ? 4'hF : a / b;
    lat  = 0;
    while (!IN_READY && lat < 50) begin tick(); lat++; end
    chk("in_ready_idle", IN_READY, 1);
    e0 = e_tot; c0 = clr_tot; r0 = run_tot; n0 = rn_noe_tot;
    OUT_READY = (hold == 0);
    IN_A = a; IN_B = b; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0; IN_A = NB'($urandom); IN_B = NB'($urandom);
    lat = 1; opnd_ok = 1'b1;
    while (!OUT_VALID && lat < 40) begin
      opnd_ok &= (DIV_A == a) && (DIV_B == b) && !IN_READY;
      tick(); lat++;
    end
    chk("latency", lat, edbz ? 1 : 13);
    chk("operands_held", opnd_ok, 1);
    chk("out_q", OUT_Q, eq);
    chk("out_dbz", OUT_DBZ, edbz);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      hold_ok &= OUT_VALID && (OUT_Q == eq) && (OUT_DBZ == edbz) && !IN_READY;
    end
    if (hold > 0) chk("backpressure_hold", hold_ok, 1);
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_A = 4'h1; IN_B = 4'h1;
    tick();
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    chk("handshake_valid_drop", OUT_VALID, 0);
    chk("no_same_cycle_accept", {IN_READY, DIV_A, DIV_B}, {1'b1, a, b});
    chk("div_e_cycles", e_tot - e0, edbz ? 0 : RC + 1);
    chk("clear_cycles", clr_tot - c0, edbz ? 0 : 1);
    chk("run_cycles", run_tot - r0, edbz ? 0 : RC);
    chk("rn_without_e", rn_noe_tot - n0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {IN_READY, DIV_E, DIV_RN, DIV_A, DIV_B, OUT_VALID, OUT_Q, OUT_DBZ},
        {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0});
  endtask

  initial begin
    R = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; OUT_READY = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset_state");
    R = 1'b0;
    tick();
    OUT_READY = 1'b1;
    tick();
    chk("ready_without_valid_ignored", {OUT_VALID, IN_READY}, 2'b01);
    OUT_READY = 1'b0;

    run_op(4'd7, 4'd2, 0);
    run_op(4'd15, 4'd1, 0);
    run_op(4'd9, 4'd3, 0);
    run_op(4'd5, 4'd0, 0);
    run_op(4'd6, 4'd2, 20);

    // Abort in the middle of the run window.
    IN_A = 4'd12; IN_B = 4'd5; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_run_enable", DIV_E && DIV_RN, 1);
    R = 1'b1;
    tick();
    R = 1'b0;
    chk_reset_outputs("reset_mid_run");
    tick();
    chk("no_result_after_abort", OUT_VALID, 0);
    run_op(4'd8, 4'd4, 0);

    for (int n = 0; n < 24; n++) begin
      logic [NB-1:0] ra, rb;
      ra = NB'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 4'd0 : NB'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
